echo_path_model: RTL
====================

# echo_path_model

Behavioural-synthesisable echo path that consumes the 16-bit random far-end sample stream and produces the microphone signal the echo canceller must clean. It delays the far-end sample by a programmable lag, scales it by a Q1.15 gain, and adds it to a near-end sample with saturation. It sits between the test signal source and the echo cancellation core. It also exports the isolated echo term as a reference for checking canceller residue.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `MAX_LAG`, 16: delay-line depth in samples; power of two, ≥2.
- `LAG_W`, $clog2(MAX_LAG): lag field width.
- `clk` input 1: single clock, rising edge. One clock domain; no other clocks.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: one sample per high cycle; may be high every cycle.
- `far_in` input WIDTH: far-end sample, signed.
- `near_in` input WIDTH: near-end sample, signed.
- `lag` input LAG_W: echo delay in samples, 0..MAX_LAG-1; sampled with `in_valid`.
- `gain` input 16: echo gain, signed Q1.15; sampled with `in_valid`.
- `out_valid` output 1: one-cycle strobe per accepted sample.
- `mic_out` output WIDTH: near + echo, saturated.
- `echo_out` output WIDTH: echo term alone, saturated.
- `primed` output 1: the delayed sample for this output was a real written sample, not zero fill.

## Operation
- Circular buffer of MAX_LAG entries, write pointer `wp` (LAG_W bits, wraps modulo MAX_LAG), fill counter `fill` (0..MAX_LAG, saturating).
- On `in_valid`:
  - Read address = `wp - lag` mod MAX_LAG, using pre-write `wp`.
  - `lag`=0 bypasses the buffer and uses `far_in`.
  - Write `far_in` at `wp`; `wp`++, `fill`++ (saturating).
- Delayed sample `d`:
  - Buffer/bypass value when `lag`==0 or `fill` (pre-write) ≥ `lag`.
  - Otherwise 0, with `primed`=0 for that sample.
- Buffer RAM has no reset; zero substitution via `fill` guarantees no X propagates.
- Echo: `p = d*gain` (32-bit signed); `e = (p + 2^14) >>> 15` (round half up); saturate to [-32768, 32767].
- Mic: `m = near + e` in 17 bits, saturated to WIDTH.
- Without `in_valid`: buffer, pointer, and fill are frozen; nothing is emitted.
- `lag` or `gain` may change on any sample and take effect for that sample. There is no flush and no ramp.
- Reset (any time):
  - Clears `wp`, `fill`, the pipeline valid bits, and all outputs to 0.
  - In-flight samples are discarded; no `out_valid` is produced for them.

## Timing
- Two-stage pipeline:
  - Edge k: `in_valid` sampled high → stage 1 registers `d`, `near`, `gain`, primed.
  - Edge k+1: stage 2 registers `echo_out`, `mic_out`, `primed`, `out_valid`=1.
  - Result is visible after edge k+1, i.e. `out_valid` high during the cycle following edge k+1 (latency 2 clocks from presentation).
- Full throughput: one sample per clock; output order equals input order.
- Outputs hold their values when `out_valid`=0. `out_valid` is deasserted the cycle after its strobe unless a new sample follows.
- Reset values: `out_valid`=0, `mic_out`=0, `echo_out`=0, `primed`=0.
- `rst_n` assertion clears outputs asynchronously. Release is treated as synchronous to `clk` by the surrounding bench.

## Structure
- Shared package `echo_pkg`:
  - `SAMPLE_W`=16, `Q15_ONE`=16'sh7FFF, `Q15_MINUS_ONE`=16'sh8000.
  - A `sat16` function: 17/32-bit signed to 16-bit saturating.
  - A `q15_mul_round` function.
- Sub-module `delay_line`:
  - Holds RAM, `wp`, `fill`, the bypass mux, and zero substitution.
  - Ports: `clk`, `rst_n`, `wr_en`, `din`, `lag`, `dout`, `valid_hist`.
- Top holds the multiply/round/saturate stage and the output registers.

## Test plan
- Reset: hold `rst_n`=0 with random inputs toggling → all outputs 0 and `out_valid`=0 throughout; after release, no `out_valid` until the first `in_valid`.
- Impulse, `lag`=4, `gain`=16'h4000, `near`=0, `far` = 1000 then zeros (back-to-back):
  - Samples 0..3: `echo_out`=0, `primed`=0.
  - Sample 4: `echo_out`=500, `primed`=1.
  - Each `out_valid` arrives exactly 2 edges after its `in_valid`.
- Saturation, `lag`=0:
  - `far`=30000, `gain`=16'h7FFF, `near`=30000 → `echo_out`=29999, `mic_out`=32767.
  - `far`=-32768, `gain`=16'h8000 → `echo_out`=32767.
  - `near`=-32768 with negative echo → `mic_out`=-32768.
- Wrap, `MAX_LAG`=16, `lag`=15, `gain`=16'h8000, `far` = n+1 for n=0..39:
  - n<15: `echo_out`=0, `primed`=0.
  - n≥15: `echo_out` = -(n-14), across two pointer wraps.
- Gapped input: `in_valid` with random 0–5 idle cycles between samples, `lag`=3 → results identical to the back-to-back run; exactly one `out_valid` per sample; no output during idle cycles.
- Mid-stream reset: pulse `rst_n` low while 2 samples are in flight → `out_valid` drops immediately and the lost samples never appear; with `lag`=4 the first 4 post-reset outputs have `echo_out`=0 and `primed`=0.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types, constants and arithmetic helpers for the echo path model.
package echo_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic signed [15:0] Q15_ONE       = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MINUS_ONE = 16'sh8000;

    // Clamp a sign-extended 17..32-bit value into the 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        logic signed [15:0] r;
        if (x > 32'sd32767) begin
            r = 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

    // Q1.15 multiply with round-half-up; result is unsaturated (may reach +32768).
    function automatic logic signed [31:0] q15_mul_round(input logic signed [15:0] a,
                                                         input logic signed [15:0] b);
        logic signed [31:0] aw;
        logic signed [31:0] bw;
        logic signed [31:0] p;
        aw = 32'(a);
        bw = 32'(b);
        p  = aw * bw;
        return (p + 32'sd16384) >>> 15;
    endfunction

endpackage

// File: rtl/echo_path_model_if.sv
// Sample-stream bundle between the signal source / bench and the echo path.
interface echo_path_model_if #(
    parameter int WIDTH = 16,
    parameter int LAG_W = 4
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] far_in;
    logic signed [WIDTH-1:0] near_in;
    logic [LAG_W-1:0]        lag;
    logic signed [15:0]      gain;
    logic                    out_valid;
    logic signed [WIDTH-1:0] mic_out;
    logic signed [WIDTH-1:0] echo_out;
    logic                    primed;

    modport master (
        output in_valid, far_in, near_in, lag, gain,
        input  out_valid, mic_out, echo_out, primed
    );

    modport slave (
        input  in_valid, far_in, near_in, lag, gain,
        output out_valid, mic_out, echo_out, primed
    );
endinterface

// File: rtl/echo_path_model_delay_line.sv
// Circular far-end delay line with lag-0 bypass and zero fill until history exists.
module delay_line
    import echo_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_W,
    parameter int MAX_LAG = 16,
    parameter int LAG_W   = $clog2(MAX_LAG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic [LAG_W-1:0] lag,
    output logic [WIDTH-1:0] dout,
    output logic             valid_hist
);

    logic [WIDTH-1:0] mem_r [MAX_LAG];
    logic [LAG_W-1:0] wp_r;
    logic [LAG_W:0]   fill_r;
    logic [LAG_W-1:0] rd_addr_s;

    // Read address uses the pre-write pointer, wrapping naturally at LAG_W bits.
    assign rd_addr_s = wp_r - lag;

    // Sample store; deliberately unreset, stale contents are masked by fill_r.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wp_r] <= din;
        end
    end

    // Write pointer and saturating fill count advance only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r   <= {LAG_W{1'b0}};
            fill_r <= {(LAG_W+1){1'b0}};
        end else if (wr_en) begin
            wp_r <= wp_r + LAG_W'(1);
            if (fill_r == (LAG_W+1)'(MAX_LAG)) begin
                fill_r <= fill_r;
            end else begin
                fill_r <= fill_r + (LAG_W+1)'(1);
            end
        end else begin
            wp_r   <= wp_r;
            fill_r <= fill_r;
        end
    end

    // Select bypass, stored sample, or zero when the requested history was never written.
    always_comb begin
        dout       = {WIDTH{1'b0}};
        valid_hist = 1'b0;
        if (lag == {LAG_W{1'b0}}) begin
            dout       = din;
            valid_hist = 1'b1;
        end else if (fill_r >= {1'b0, lag}) begin
            dout       = mem_r[rd_addr_s];
            valid_hist = 1'b1;
        end else begin
            dout       = {WIDTH{1'b0}};
            valid_hist = 1'b0;
        end
    end

endmodule

// File: rtl/echo_path_model.sv
// Echo path: delayed far-end sample scaled by a Q1.15 gain and added to near-end.
module echo_path_model
    import echo_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_W,
    parameter int MAX_LAG = 16,
    parameter int LAG_W   = $clog2(MAX_LAG)
) (
    input  logic         clk,
    input  logic         rst_n,
    echo_path_model_if.slave bus
);

    logic [WIDTH-1:0]        dl_dout_s;
    logic                    dl_hist_s;

    logic signed [WIDTH-1:0] d_r;
    logic signed [WIDTH-1:0] near_r;
    logic signed [15:0]      gain_r;
    logic                    primed1_r;
    logic                    v1_r;

    logic signed [15:0]      echo_s;
    logic signed [15:0]      mic_s;

    logic signed [WIDTH-1:0] echo_r;
    logic signed [WIDTH-1:0] mic_r;
    logic                    primed_r;
    logic                    out_valid_r;

    delay_line #(
        .WIDTH   (WIDTH),
        .MAX_LAG (MAX_LAG),
        .LAG_W   (LAG_W)
    ) u_delay_line (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.in_valid),
        .din        (bus.far_in),
        .lag        (bus.lag),
        .dout       (dl_dout_s),
        .valid_hist (dl_hist_s)
    );

    // Stage 1: capture delayed sample and the per-sample operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r       <= {WIDTH{1'b0}};
            near_r    <= {WIDTH{1'b0}};
            gain_r    <= 16'sh0000;
            primed1_r <= 1'b0;
            v1_r      <= 1'b0;
        end else if (bus.in_valid) begin
            d_r       <= dl_dout_s;
            near_r    <= bus.near_in;
            gain_r    <= bus.gain;
            primed1_r <= dl_hist_s;
            v1_r      <= 1'b1;
        end else begin
            d_r       <= d_r;
            near_r    <= near_r;
            gain_r    <= gain_r;
            primed1_r <= primed1_r;
            v1_r      <= 1'b0;
        end
    end

    // Echo term is rounded then clamped; mic sum is formed wide and clamped.
    always_comb begin
        echo_s = 16'sh0000;
        mic_s  = 16'sh0000;
        echo_s = sat16(q15_mul_round(d_r, gain_r));
        mic_s  = sat16(32'(near_r) + 32'(echo_s));
    end

    // Stage 2: output registers hold their value between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_r      <= {WIDTH{1'b0}};
            mic_r       <= {WIDTH{1'b0}};
            primed_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (v1_r) begin
            echo_r      <= echo_s;
            mic_r       <= mic_s;
            primed_r    <= primed1_r;
            out_valid_r <= 1'b1;
        end else begin
            echo_r      <= echo_r;
            mic_r       <= mic_r;
            primed_r    <= primed_r;
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.echo_out  = echo_r;
    assign bus.mic_out   = mic_r;
    assign bus.primed    = primed_r;

endmodule
